// File: rtl/set_bit_iterator_pkg.sv
// Shared types for the set-bit iterator: FSM state encoding.
// Kept in a package so other sequencing blocks can refer to the same states.
package set_bit_iterator_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage : set_bit_iterator_pkg

// File: rtl/onehot_to_bin.sv
// Combinational one-hot to binary encoder, shared with other blocks.
// An all-zero input encodes to 0; a multi-hot input ORs the indices together.
module onehot_to_bin #(
    parameter  int WIDTH = 16,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] onehot,
    output logic [IDX_W-1:0] idx
);

    always_comb begin
        idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (onehot[i]) begin
                idx = idx | IDX_W'(i);
            end
        end
    end

endmodule : onehot_to_bin

// File: rtl/set_bit_iterator.sv
// Expands an accepted word into one beat per set bit, LSB first, with
// valid/ready backpressure. All outputs are decoded from registers only.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | ready for a new word; no beat presented
// RUN   | presenting lowest set bit of residual; input side stalled
module set_bit_iterator
    import set_bit_iterator_pkg::*;
#(
    parameter  int WIDTH = 16,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             srst_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             data_val_i,
    output logic             data_ready_o,
    output logic [WIDTH-1:0] bit_o,
    output logic [IDX_W-1:0] bit_idx_o,
    output logic             bit_last_o,
    output logic             bit_empty_o,
    output logic             bit_val_o,
    input  logic             bit_ready_i
);

    state_t           state;
    logic [WIDTH-1:0] residual;
    logic             empty_q;

    logic             run;
    logic [WIDTH-1:0] low_bit;
    logic [WIDTH-1:0] remaining;
    logic [IDX_W-1:0] low_idx;
    logic             last;

    assign run       = (state == RUN);
    assign low_bit   = residual & (~residual + WIDTH'(1));
    assign remaining = residual & ~low_bit;
    assign last      = empty_q || (remaining == '0);

    onehot_to_bin #(
        .WIDTH (WIDTH)
    ) u_enc (
        .onehot (low_bit),
        .idx    (low_idx)
    );

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state    <= IDLE;
            residual <= '0;
            empty_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (data_val_i) begin
                        residual <= data_i;
                        empty_q  <= (data_i == '0);
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (bit_ready_i) begin
                        residual <= remaining;
                        if (last) begin
                            empty_q <= 1'b0;
                            state   <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Residual is cleared by the final transfer, but gate anyway so IDLE
    // outputs never depend on what the register happens to hold.
    assign data_ready_o = ~run;
    assign bit_val_o    = run;
    assign bit_o        = run ? low_bit : '0;
    assign bit_idx_o    = run ? low_idx : '0;
    assign bit_last_o   = run & last;
    assign bit_empty_o  = run & empty_q;

endmodule : set_bit_iterator

// File: tb/tb_set_bit_iterator.sv
// Directed bench for set_bit_iterator (WIDTH=16) with hand-computed beats.
module tb_set_bit_iterator;

    logic        clk_i = 1'b0;
    logic        srst_i = 1'b1;
    logic [15:0] data_i = '0;
    logic        data_val_i = 1'b0;
    logic        data_ready_o;
    logic [15:0] bit_o;
    logic [3:0]  bit_idx_o;
    logic        bit_last_o;
    logic        bit_empty_o;
    logic        bit_val_o;
    logic        bit_ready_i = 1'b0;

    int checks = 0;
    int errors = 0;

    set_bit_iterator #(.WIDTH(16)) dut (
        .clk_i        (clk_i),
        .srst_i       (srst_i),
        .data_i       (data_i),
        .data_val_i   (data_val_i),
        .data_ready_o (data_ready_o),
        .bit_o        (bit_o),
        .bit_idx_o    (bit_idx_o),
        .bit_last_o   (bit_last_o),
        .bit_empty_o  (bit_empty_o),
        .bit_val_o    (bit_val_o),
        .bit_ready_i  (bit_ready_i)
    );

    always #5 clk_i = ~clk_i;

    // Advance one edge; inputs change and outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic accept(input logic [15:0] word);
        data_i     = word;
        data_val_i = 1'b1;
        step();
        data_val_i = 1'b0;
    endtask

    task automatic test_reset();
        srst_i = 1'b1;
        step();
        step();
        srst_i = 1'b0;
        checks++;
        if (data_ready_o !== 1'b1 || bit_val_o !== 1'b0 || bit_o !== 16'h0 ||
            bit_idx_o !== 4'd0 || bit_last_o !== 1'b0 || bit_empty_o !== 1'b0) begin
            errors++;
            $display("FAIL reset: ready=%b val=%b bit=%h idx=%0d last=%b empty=%b, want 1 0 0000 0 0 0",
                     data_ready_o, bit_val_o, bit_o, bit_idx_o, bit_last_o, bit_empty_o);
        end
    endtask

    task automatic test_sparse();
        logic [15:0] exp_bit [4];
        logic [3:0]  exp_idx [4];
        exp_bit = '{16'h0001, 16'h0020, 16'h0400, 16'h8000};
        exp_idx = '{4'd0, 4'd5, 4'd10, 4'd15};
        bit_ready_i = 1'b1;
        accept(16'h8421);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (bit_val_o !== 1'b1 || bit_o !== exp_bit[k] || bit_idx_o !== exp_idx[k] ||
                bit_last_o !== (k == 3) || data_ready_o !== 1'b0 || bit_empty_o !== 1'b0) begin
                errors++;
                $display("FAIL sparse beat %0d: val=%b bit=%h idx=%0d last=%b ready=%b empty=%b, want 1 %h %0d %b 0 0",
                         k, bit_val_o, bit_o, bit_idx_o, bit_last_o, data_ready_o, bit_empty_o,
                         exp_bit[k], exp_idx[k], (k == 3));
            end
            step();
        end
        checks++;
        if (data_ready_o !== 1'b1 || bit_val_o !== 1'b0) begin
            errors++;
            $display("FAIL sparse done: ready=%b val=%b, want 1 0", data_ready_o, bit_val_o);
        end
    endtask

    task automatic test_empty();
        bit_ready_i = 1'b1;
        accept(16'h0000);
        checks++;
        if (bit_val_o !== 1'b1 || bit_o !== 16'h0 || bit_idx_o !== 4'd0 ||
            bit_empty_o !== 1'b1 || bit_last_o !== 1'b1) begin
            errors++;
            $display("FAIL empty beat: val=%b bit=%h idx=%0d empty=%b last=%b, want 1 0000 0 1 1",
                     bit_val_o, bit_o, bit_idx_o, bit_empty_o, bit_last_o);
        end
        step();
        checks++;
        if (data_ready_o !== 1'b1 || bit_val_o !== 1'b0 || bit_empty_o !== 1'b0) begin
            errors++;
            $display("FAIL empty done: ready=%b val=%b empty=%b, want 1 0 0",
                     data_ready_o, bit_val_o, bit_empty_o);
        end
    endtask

    task automatic test_backpressure();
        bit_ready_i = 1'b0;
        accept(16'h0003);
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (bit_val_o !== 1'b1 || bit_o !== 16'h0001 || bit_idx_o !== 4'd0 || bit_last_o !== 1'b0) begin
                errors++;
                $display("FAIL backpressure hold %0d: val=%b bit=%h idx=%0d last=%b, want 1 0001 0 0",
                         c, bit_val_o, bit_o, bit_idx_o, bit_last_o);
            end
            if (c == 3) bit_ready_i = 1'b1;
            step();
        end
        checks++;
        if (bit_val_o !== 1'b1 || bit_o !== 16'h0002 || bit_idx_o !== 4'd1 || bit_last_o !== 1'b1) begin
            errors++;
            $display("FAIL backpressure second: val=%b bit=%h idx=%0d last=%b, want 1 0002 1 1",
                     bit_val_o, bit_o, bit_idx_o, bit_last_o);
        end
        step();
        checks++;
        if (data_ready_o !== 1'b1 || bit_val_o !== 1'b0) begin
            errors++;
            $display("FAIL backpressure done: ready=%b val=%b, want 1 0", data_ready_o, bit_val_o);
        end
    endtask

    task automatic test_input_while_busy();
        bit_ready_i = 1'b1;
        accept(16'h00F0);
        data_i     = 16'hFFFF;
        data_val_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (bit_val_o !== 1'b1 || bit_idx_o !== 4'(4 + k) || bit_last_o !== (k == 3) ||
                data_ready_o !== 1'b0) begin
                errors++;
                $display("FAIL busy beat %0d: val=%b idx=%0d last=%b ready=%b, want 1 %0d %b 0",
                         k, bit_val_o, bit_idx_o, bit_last_o, data_ready_o, 4 + k, (k == 3));
            end
            step();
        end
        // Drop the request before the next edge so 0xFFFF is never legitimately accepted.
        data_val_i = 1'b0;
        checks++;
        if (bit_val_o !== 1'b0 || data_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL busy done: val=%b ready=%b, want 0 1", bit_val_o, data_ready_o);
        end
    endtask

    task automatic test_reset_mid_run();
        bit_ready_i = 1'b1;
        accept(16'hFFFF);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (bit_val_o !== 1'b1 || bit_idx_o !== 4'(k)) begin
                errors++;
                $display("FAIL midrst beat %0d: val=%b idx=%0d, want 1 %0d", k, bit_val_o, bit_idx_o, k);
            end
            step();
        end
        srst_i = 1'b1;
        step();
        srst_i = 1'b0;
        checks++;
        if (bit_val_o !== 1'b0 || data_ready_o !== 1'b1 || bit_o !== 16'h0) begin
            errors++;
            $display("FAIL midrst after reset: val=%b ready=%b bit=%h, want 0 1 0000",
                     bit_val_o, data_ready_o, bit_o);
        end
        accept(16'h0100);
        checks++;
        if (bit_val_o !== 1'b1 || bit_o !== 16'h0100 || bit_idx_o !== 4'd8 ||
            bit_last_o !== 1'b1 || bit_empty_o !== 1'b0) begin
            errors++;
            $display("FAIL midrst next word: val=%b bit=%h idx=%0d last=%b empty=%b, want 1 0100 8 1 0",
                     bit_val_o, bit_o, bit_idx_o, bit_last_o, bit_empty_o);
        end
        step();
        checks++;
        if (data_ready_o !== 1'b1 || bit_val_o !== 1'b0) begin
            errors++;
            $display("FAIL midrst done: ready=%b val=%b, want 1 0", data_ready_o, bit_val_o);
        end
    endtask

    task automatic test_full_word();
        int n;
        logic [15:0] exp_bit;
        n = 0;
        bit_ready_i = 1'b1;
        accept(16'hFFFF);
        for (int c = 0; c < 40 && bit_val_o === 1'b1; c++) begin
            exp_bit = 16'h0001 << n;
            checks++;
            if (bit_idx_o !== 4'(n) || bit_o !== exp_bit || bit_last_o !== (n == 15)) begin
                errors++;
                $display("FAIL full beat %0d: bit=%h idx=%0d last=%b, want %h %0d %b",
                         n, bit_o, bit_idx_o, bit_last_o, exp_bit, n, (n == 15));
            end
            n++;
            step();
        end
        checks++;
        if (n != 16 || data_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL full count: beats=%0d ready=%b, want 16 1", n, data_ready_o);
        end
    endtask

    initial begin
        test_reset();
        test_sparse();
        test_empty();
        test_backpressure();
        test_input_while_busy();
        test_reset_mid_run();
        test_full_word();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_set_bit_iterator
